// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: spawns a mole from an LFSR, waits for a
// guess edge or a timeout, scores the round, pauses, and ends the game
// after MAX_MISSES misses.
module mole_round_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned REVEAL_CYCLES  = 25000000,
  parameter int unsigned MAX_MISSES     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eval_now,
  input  logic [2:0] user_guess,
  output logic       guess_now,
  output logic [2:0] mole_pos,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > REVEAL_CYCLES) ? TIMEOUT_CYCLES : REVEAL_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned LFSR_W  = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [2:0] POS_NONE = 3'd7;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REVEAL_LAST  = CNT_W'(REVEAL_CYCLES - 1);
  localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_WAIT,
    ST_RESULT,
    ST_OVER
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_next;
  logic              w_lfsr_fb;
  logic              r_eval_d;
  logic              w_edge;
  logic              w_guess_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  logic [2:0]        r_pos;
  logic [2:0]        w_next_pos;
  logic [2:0]        w_spawn_pos;
  logic              w_hit;
  logic              w_miss;
  logic              r_guess_now;
  logic [2:0]        r_mole_pos;
  logic [7:0]        r_score;
  logic [3:0]        r_misses;
  logic              r_hit_pulse;
  logic              r_miss_pulse;
  logic              r_game_over;

  // Pseudo-random source: x^8+x^6+x^5+x^4+1, reseeded if it ever hits zero
  assign w_lfsr_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_lfsr_next = (r_lfsr == '0) ? LFSR_SEED : {r_lfsr[LFSR_W-2:0], w_lfsr_fb};

  // Fold the 3-bit LFSR slice onto holes 0..4
  assign w_spawn_pos = (r_lfsr[2:0] < 3'd5) ? r_lfsr[2:0] : (r_lfsr[2:0] - 3'd3);

  // Rising edge of the guess-valid level; a level held across entry is not an edge
  assign w_edge        = eval_now & ~r_eval_d;
  assign w_guess_valid = w_edge & (user_guess <= 3'd4);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, round counter, latched position and result decode
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_pos   = r_pos;
    w_hit        = 1'b0;
    w_miss       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_SPAWN;
      end
      ST_SPAWN: begin
        w_next_pos   = w_spawn_pos;
        w_next_cnt   = '0;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_guess_valid) begin
          w_hit        = (user_guess == r_pos);
          w_miss       = (user_guess != r_pos);
          w_next_cnt   = '0;
          w_next_state = ST_RESULT;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_miss       = 1'b1;
          w_next_cnt   = '0;
          w_next_state = ST_RESULT;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESULT: begin
        if (r_cnt == REVEAL_LAST) begin
          w_next_cnt   = '0;
          w_next_state = (r_misses >= MISS_LIMIT) ? ST_OVER : ST_SPAWN;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_OVER: begin
        w_next_state = ST_OVER;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: LFSR, edge detector, counter, position, tallies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr   <= LFSR_SEED;
      r_eval_d <= 1'b0;
      r_cnt    <= '0;
      r_pos    <= '0;
      r_score  <= '0;
      r_misses <= '0;
    end else begin
      r_lfsr   <= w_lfsr_next;
      r_eval_d <= eval_now;
      r_cnt    <= w_next_cnt;
      r_pos    <= w_next_pos;
      if (w_hit && (r_score != 8'hFF)) begin
        r_score <= r_score + 8'd1;
      end
      if (w_miss && (r_misses != 4'hF)) begin
        r_misses <= r_misses + 4'd1;
      end
    end
  end

  // Registered outputs, decoded from the next state so they move with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_guess_now  <= 1'b0;
      r_mole_pos   <= POS_NONE;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_guess_now  <= (w_next_state == ST_WAIT);
      r_mole_pos   <= (w_next_state == ST_WAIT) ? w_next_pos : POS_NONE;
      r_hit_pulse  <= w_hit;
      r_miss_pulse <= w_miss;
      r_game_over  <= (w_next_state == ST_OVER);
    end
  end

  assign guess_now  = r_guess_now;
  assign mole_pos   = r_mole_pos;
  assign score      = r_score;
  assign misses     = r_misses;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: directed and randomized rounds checked against
// a round-level model (LFSR sequence, fixed phase lengths, running tallies).
module tb_mole_round_ctrl;

  localparam int unsigned TO  = 20;
  localparam int unsigned RV  = 4;
  localparam int unsigned MM  = 3;

  localparam int K_TIMEOUT = 0;
  localparam int K_RIGHT   = 1;
  localparam int K_WRONG   = 2;
  localparam int K_INVALID = 3;
  localparam int K_HOLD    = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       eval_now;
  logic [2:0] user_guess;
  logic       guess_now;
  logic [2:0] mole_pos;
  logic [7:0] score;
  logic [3:0] misses;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_lfsr;
  logic [7:0] m_prev;
  int         m_score;
  int         m_misses;

  mole_round_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .REVEAL_CYCLES (RV),
    .MAX_MISSES    (MM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .eval_now  (eval_now),
    .user_guess(user_guess),
    .guess_now (guess_now),
    .mole_pos  (mole_pos),
    .score     (score),
    .misses    (misses),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    // Polynomial x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [2:0] hole_of(input logic [7:0] v);
    int s;
    s = int'(v[2:0]);
    if (s >= 5) s = s - 3;
    return 3'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model LFSR advances with the edge; sample at the falling edge
  task automatic tick();
    @(posedge clk);
    m_prev = m_lfsr;
    m_lfsr = lfsr_step(m_lfsr);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_guess_now"},  32'(guess_now),  32'd0);
    chk({tag, "_mole_pos"},   32'(mole_pos),   32'd7);
    chk({tag, "_score"},      32'(score),      32'd0);
    chk({tag, "_misses"},     32'(misses),     32'd0);
    chk({tag, "_hit_pulse"},  32'(hit_pulse),  32'd0);
    chk({tag, "_miss_pulse"}, 32'(miss_pulse), 32'd0);
    chk({tag, "_game_over"},  32'(game_over),  32'd0);
  endtask

  // Reset, release, and step through IDLE and SPAWN into the first WAIT cycle
  task automatic restart();
    rst_n    = 1'b0;
    eval_now = 1'b0;
    user_guess = 3'd7;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n    = 1'b1;
    m_lfsr   = 8'hA5;
    m_prev   = 8'hA5;
    m_score  = 0;
    m_misses = 0;
    tick();
    chk("spawn_guess_now", 32'(guess_now), 32'd0);
    chk("spawn_mole_pos",  32'(mole_pos),  32'd7);
    tick();
  endtask

  // Play one round from the first WAIT cycle to the next WAIT cycle or OVER
  task automatic round(input int kind, input int dly, input bit keep);
    logic [2:0] exp_pos;
    logic [2:0] g;
    bit hit;
    bit miss;
    exp_pos = hole_of(m_prev);
    chk("wait_guess_now", 32'(guess_now), 32'd1);
    chk("wait_mole_pos",  32'(mole_pos),  32'(exp_pos));
    hit  = 1'b0;
    miss = 1'b0;
    if (kind == K_RIGHT || kind == K_WRONG) begin
      if (kind == K_RIGHT) g = exp_pos;
      else g = 3'((int'(exp_pos) + 1 + int'($urandom_range(0, 3))) % 5);
      eval_now = 1'b0;
      repeat (dly) tick();
      eval_now   = 1'b1;
      user_guess = g;
      tick();
      hit  = (kind == K_RIGHT);
      miss = (kind == K_WRONG);
    end else begin
      if (kind != K_HOLD) eval_now = 1'b0;
      for (int i = 0; i < int'(TO); i++) begin
        if (kind == K_INVALID && i == dly) begin
          eval_now   = 1'b1;
          user_guess = 3'(5 + $urandom_range(0, 2));
        end
        if (kind == K_INVALID && i == dly + 1) eval_now = 1'b0;
        if (i == int'(TO) - 1) chk("still_waiting", 32'(guess_now), 32'd1);
        tick();
      end
      miss = 1'b1;
    end
    if (hit && m_score < 255) m_score++;
    if (miss) m_misses++;
    chk("res_hit_pulse",  32'(hit_pulse),  32'(hit));
    chk("res_miss_pulse", 32'(miss_pulse), 32'(miss));
    chk("res_score",      32'(score),      32'(m_score));
    chk("res_misses",     32'(misses),     32'(m_misses));
    chk("res_guess_now",  32'(guess_now),  32'd0);
    chk("res_mole_pos",   32'(mole_pos),   32'd7);
    if (!keep) eval_now = 1'b0;
    for (int i = 1; i < int'(RV); i++) begin
      tick();
      chk("res_pulse_once", 32'({hit_pulse, miss_pulse}), 32'd0);
      chk("res_hold_guess", 32'(guess_now), 32'd0);
    end
    tick();
    if (m_misses >= int'(MM)) begin
      chk("over_game_over", 32'(game_over), 32'd1);
      chk("over_guess_now", 32'(guess_now), 32'd0);
      repeat (6) tick();
      chk("over_stays",     32'(game_over), 32'd1);
      chk("over_guess_off", 32'(guess_now), 32'd0);
      chk("over_mole_pos",  32'(mole_pos),  32'd7);
      chk("over_score",     32'(score),     32'(m_score));
      chk("over_misses",    32'(misses),    32'(m_misses));
    end else begin
      chk("next_spawn_guess", 32'(guess_now), 32'd0);
      chk("next_spawn_over",  32'(game_over), 32'd0);
      tick();
    end
  endtask

  initial begin
    int kind;
    int games;
    int rounds;

    eval_now   = 1'b0;
    user_guess = 3'd7;
    rst_n      = 1'b0;

    // Bring-up: first mole comes from the seeded LFSR
    restart();
    chk("first_pos_range", 32'(mole_pos <= 3'd4), 32'd1);

    // Correct guess scores a hit
    round(K_RIGHT, 3, 1'b0);
    // Three timeouts end the game
    round(K_TIMEOUT, 0, 1'b0);
    round(K_TIMEOUT, 0, 1'b0);
    round(K_TIMEOUT, 0, 1'b0);
    chk("game_ended", 32'(game_over), 32'd1);

    // Level held across RESULT into the next round is not a guess
    restart();
    eval_now = 1'b0;
    round(K_RIGHT, 2, 1'b1);
    round(K_HOLD, 0, 1'b0);

    // Guess on the timeout cycle wins; out-of-range guess is ignored
    round(K_RIGHT, int'(TO) - 1, 1'b0);
    round(K_INVALID, 5, 1'b0);

    // Score saturates at 255
    restart();
    for (int n = 0; n < 258; n++) round(K_RIGHT, int'($urandom_range(0, 3)), 1'b0);
    chk("score_saturated", 32'(score), 32'd255);

    // Asynchronous reset in the middle of WAIT_GUESS
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");

    // Randomized games
    games  = 0;
    rounds = 0;
    restart();
    while (games < 3 && rounds < 200) begin
      kind = int'($urandom_range(0, 3));
      if (kind == K_INVALID) round(kind, int'($urandom_range(0, TO - 2)), 1'b0);
      else round(kind, int'($urandom_range(0, TO - 1)), 1'b0);
      rounds++;
      if (m_misses >= int'(MM)) begin
        games++;
        if (games < 3) restart();
      end
    end
    chk("random_games_done", 32'(games), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
